// File: rtl/dma_engine.sv
// Single-channel word-copy DMA master: CPU-programmed SRC/DST/LEN, read-then-write
// per word, bus released for one cycle between words so other masters can win arbitration.
`timescale 1ns/1ps
module dma_engine #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cfg_we,
    input  logic [1:0]        i_cfg_addr,
    input  logic [31:0]       i_cfg_wdata,
    output logic [31:0]       o_cfg_rdata,
    output logic              o_req_dma,
    input  logic              i_gnt_dma,
    output logic              o_bus_valid,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_wdata,
    input  logic [DATA_W-1:0] i_bus_rdata,
    input  logic              i_bus_ready,
    output logic              o_irq_done
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_WR, S_GAP, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic                done_q, done_d;
    logic                ie_q, ie_d;
    logic                busy;
    logic                start;
    logic                unused_wdata;

    assign busy         = (state_q != S_IDLE);
    assign o_irq_done   = done_q & ie_q;
    assign unused_wdata = i_cfg_wdata[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            buf_q   <= '0;
            done_q  <= 1'b0;
            ie_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            buf_q   <= buf_d;
            done_q  <= done_d;
            ie_q    <= ie_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        buf_d       = buf_q;
        done_d      = done_q;
        ie_d        = ie_q;
        start       = 1'b0;
        o_req_dma   = 1'b0;
        o_bus_valid = 1'b0;
        o_bus_we    = 1'b0;
        o_bus_addr  = '0;
        o_bus_wdata = '0;

        // SRC/DST/LEN double as the working counters, so they are frozen to the CPU while busy.
        if (i_cfg_we) begin
            case (i_cfg_addr)
                2'd0: if (!busy) src_d = {i_cfg_wdata[ADDR_W-1:2], 2'b00};
                2'd1: if (!busy) dst_d = {i_cfg_wdata[ADDR_W-1:2], 2'b00};
                2'd2: if (!busy) len_d = i_cfg_wdata[LEN_W-1:0];
                default: begin
                    start = i_cfg_wdata[0];
                    ie_d  = i_cfg_wdata[3];
                    if (i_cfg_wdata[2]) done_d = 1'b0;
                end
            endcase
        end

        case (state_q)
            S_IDLE: if (start) state_d = (len_q == '0) ? S_DONE : S_REQ;
            S_REQ: begin
                o_req_dma = 1'b1;
                if (i_gnt_dma) state_d = S_RD;
            end
            S_RD: begin
                o_req_dma   = 1'b1;
                o_bus_valid = i_gnt_dma;
                o_bus_addr  = src_q;
                if (i_gnt_dma && i_bus_ready) begin
                    buf_d   = i_bus_rdata;
                    src_d   = src_q + ADDR_W'(4);
                    state_d = S_WR;
                end
            end
            S_WR: begin
                o_req_dma   = 1'b1;
                o_bus_valid = i_gnt_dma;
                o_bus_we    = 1'b1;
                o_bus_addr  = dst_q;
                o_bus_wdata = buf_q;
                if (i_gnt_dma && i_bus_ready) begin
                    dst_d   = dst_q + ADDR_W'(4);
                    len_d   = len_q - LEN_W'(1);
                    state_d = (len_q == LEN_W'(1)) ? S_DONE : S_GAP;
                end
            end
            S_GAP:  state_d = S_REQ;
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (i_cfg_addr)
            2'd0:    o_cfg_rdata = 32'(src_q);
            2'd1:    o_cfg_rdata = 32'(dst_q);
            2'd2:    o_cfg_rdata = 32'(len_q);
            default: o_cfg_rdata = {28'd0, ie_q, done_q, busy, 1'b0};
        endcase
    end

endmodule
